panel_control: RTL
==================

PANEL_CONTROL -- requirements
Module: panel_control

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000: stable cycles required before a switch change is accepted; 16-bit; legal range 1..65535.
REQ-002 SHALL have parameter RESET_HOLD_CYCLES, default 16'd1024: cycles CPU_RESET stays asserted after run is requested; 16-bit; 0 legal.
REQ-003 SHALL have CPUCLK_IN, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have RESET_IN, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have STEP_SW_IN, input, 1: raw step push-switch, asynchronous, bouncy, 1=pressed.
REQ-006 SHALL have STEPEN_SW_IN, input, 1: raw step-mode toggle switch, asynchronous, bouncy, 1=step mode.
REQ-007 SHALL have RUN_SW_IN, input, 1: raw run/halt toggle switch, asynchronous, bouncy, 1=run.
REQ-008 SHALL have STEP, output, 1: debounced step level, fed to the bus controller's step input.
REQ-009 SHALL have STEP_PULSE, output, 1: one-cycle pulse on each debounced STEP rise.
REQ-010 SHALL have STEPEN, output, 1: debounced step-mode level, fed to the bus controller's step-enable input.
REQ-011 SHALL have RUN, output, 1: 1 only in state RUNNING; fed to the bus controller's run input.
REQ-012 SHALL have CPU_RESET, output, 1: active-high CPU reset/halt request, driven externally to the 68000 RESET/HALT pins.
REQ-013 SHALL have STEP_COUNT, output, 8: count of accepted step presses.

Function
REQ-014 Each raw switch SHALL pass through its own 2-flop synchronizer before any other use.
REQ-015 Each synchronized switch SHALL have a dedicated 16-bit debounce counter: cleared in any cycle where synchronized value equals debounced output, otherwise incremented.
REQ-016 The debounced output SHALL take the synchronized value, and the counter SHALL clear, in the cycle the counter would reach DEBOUNCE_CYCLES.
REQ-017 Any glitch shorter than DEBOUNCE_CYCLES SHALL leave the debounced output unchanged. Latency from a clean raw edge to the debounced output SHALL be exactly 2+DEBOUNCE_CYCLES cycles.
REQ-018 STEP_PULSE SHALL be 1 for exactly the cycle after STEP goes 0->1; never on a 1->0 transition.
REQ-019 The run sequencer SHALL have three states:
  - HALT: RUN=0, CPU_RESET=1.
  - RESETTING: RUN=0, CPU_RESET=1.
  - RUNNING: RUN=1, CPU_RESET=0.
REQ-020 In HALT with the debounced run switch at 1, the sequencer SHALL go to RESETTING and load the hold counter with RESET_HOLD_CYCLES.
REQ-021 In RESETTING, the hold counter SHALL decrement each cycle. When it is 0, the sequencer SHALL go to RUNNING, so RESETTING lasts RESET_HOLD_CYCLES+1 cycles (1 cycle when the parameter is 0).
REQ-022 In RESETTING or RUNNING with the debounced run switch at 0, the sequencer SHALL go to HALT on the next edge; this takes priority over the hold-counter expiry.
REQ-023 STEP_COUNT SHALL increment by 1 on each STEP_PULSE, wrapping 255->0, and SHALL clear on the HALT->RESETTING transition. If both occur in the same cycle, the clear wins.
REQ-024 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-025 While RESET_IN=1, the block SHALL set: synchronizers, debounced levels and all counters to 0; state HALT; STEP=0, STEP_PULSE=0, STEPEN=0, RUN=0, CPU_RESET=1, STEP_COUNT=0.
REQ-026 RESET_IN asserted mid-RESETTING or mid-RUNNING SHALL force HALT on that edge. After release, the block SHALL re-run the full debounce and hold sequence before RUN returns to 1.

Configuration
REQ-027 Macro STEP_COUNTER_EN:
  - Defined: STEP_COUNT behaves per REQ-023.
  - Undefined: the counter logic is absent and STEP_COUNT is constant 8'h00.
  - STEP_PULSE is present in both builds.

Verification (DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=8)
REQ-028 RUN_SW_IN held 1 from cycle 0, after reset release -> RUN rises, CPU_RESET falls in the same cycle, 2+4+9=15 cycles after the switch is first sampled.
REQ-029 STEP_SW_IN bounces with pulses of 1,2,3 cycles then holds 1 -> STEP rises exactly 6 cycles after the final stable edge, with a single STEP_PULSE; no STEP change during the bounce.
REQ-030 RUN_SW_IN dropped to 0 during RESETTING at hold count 3 -> HALT, RUN=0, CPU_RESET=1; a later return to 1 reloads the hold count to 8.
REQ-031 With STEP_COUNTER_EN defined, 257 clean step presses -> STEP_COUNT=1; re-run the sequence (HALT->RESETTING) -> STEP_COUNT=0. With the macro undefined, STEP_COUNT stays 0 throughout.
REQ-032 RESET_IN pulsed for 1 cycle while RUNNING -> next cycle RUN=0, CPU_RESET=1, STEPEN=0, STEP_COUNT=0.

Source files
------------

// File: rtl/panel_control.sv
// Front-panel controller: synchronizes and debounces the STEP, STEPEN and RUN
// switches, sequences the CPU reset/run request and counts step presses.
// Optional feature macro: STEP_COUNTER_EN enables the step-press counter;
// without it STEP_COUNT is tied to 8'h00.
module panel_control #(
    parameter logic [15:0] DEBOUNCE_CYCLES   = 16'd50000,
    parameter logic [15:0] RESET_HOLD_CYCLES = 16'd1024
) (
    input  logic       CPUCLK_IN,
    input  logic       RESET_IN,
    input  logic       STEP_SW_IN,
    input  logic       STEPEN_SW_IN,
    input  logic       RUN_SW_IN,
    output logic       STEP,
    output logic       STEP_PULSE,
    output logic       STEPEN,
    output logic       RUN,
    output logic       CPU_RESET,
    output logic [7:0] STEP_COUNT
);

    typedef enum logic [1:0] {
        ST_HALT      = 2'd0,
        ST_RESETTING = 2'd1,
        ST_RUNNING   = 2'd2
    } state_t;

    // Switch index: 0 = step, 1 = step enable, 2 = run.
    logic [2:0]        sync1_q;
    logic [2:0]        sync2_q;
    logic [2:0]        db_q;
    logic [2:0]        db_d;
    logic [2:0][15:0]  cnt_q;
    logic [2:0][15:0]  cnt_d;
    state_t            state_q;
    state_t            state_d;
    logic [15:0]       hold_q;
    logic [15:0]       hold_d;
    logic              pulse_q;
    logic              pulse_d;
    logic              run_q;
    logic              cpu_reset_q;

    // Debounce: a switch is accepted once its synchronized value has
    // disagreed with the debounced level for DEBOUNCE_CYCLES straight cycles.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = 16'd0;
                db_d[i]  = db_q[i];
            end else if ((cnt_q[i] + 16'd1) == DEBOUNCE_CYCLES) begin
                cnt_d[i] = 16'd0;
                db_d[i]  = sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
                db_d[i]  = db_q[i];
            end
        end
    end

    // Step pulse marks the edge at which the debounced step level rises.
    assign pulse_d = db_d[0] & ~db_q[0];

    // Run sequencer next state; it follows the freshly debounced run level so
    // that the HALT->RESETTING step coincides with the debounce acceptance.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_HALT: begin
                if (db_d[2]) begin
                    state_d = ST_RESETTING;
                    hold_d  = RESET_HOLD_CYCLES;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_RESETTING: begin
                if (!db_d[2]) begin
                    state_d = ST_HALT;
                end else if (hold_q == 16'd0) begin
                    state_d = ST_RUNNING;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            ST_RUNNING: begin
                if (!db_d[2]) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUNNING;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // Synchronizers, debounce state, sequencer and registered outputs.
    always_ff @(posedge CPUCLK_IN) begin
        if (RESET_IN) begin
            sync1_q     <= 3'b000;
            sync2_q     <= 3'b000;
            db_q        <= 3'b000;
            cnt_q       <= {3{16'd0}};
            state_q     <= ST_HALT;
            hold_q      <= 16'd0;
            pulse_q     <= 1'b0;
            run_q       <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            sync1_q     <= {RUN_SW_IN, STEPEN_SW_IN, STEP_SW_IN};
            sync2_q     <= sync1_q;
            db_q        <= db_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            pulse_q     <= pulse_d;
            run_q       <= (state_d == ST_RUNNING);
            cpu_reset_q <= (state_d != ST_RUNNING);
        end
    end

    assign STEP       = db_q[0];
    assign STEPEN     = db_q[1];
    assign STEP_PULSE = pulse_q;
    assign RUN        = run_q;
    assign CPU_RESET  = cpu_reset_q;

`ifdef STEP_COUNTER_EN
    logic [7:0] count_q;
    logic [7:0] count_d;
    logic       clr_count_s;

    assign clr_count_s = (state_q == ST_HALT) && (state_d == ST_RESETTING);

    // Step counter: a new run sequence clears it, and that clear beats a pulse.
    always_comb begin
        count_d = count_q;
        if (clr_count_s) begin
            count_d = 8'd0;
        end else if (pulse_q) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Step counter register.
    always_ff @(posedge CPUCLK_IN) begin
        if (RESET_IN) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign STEP_COUNT = count_q;
`else
    assign STEP_COUNT = 8'h00;
`endif

endmodule
